// File: rtl/ddram_responder_if.sv
// rtl/ddram_responder_if.sv - DDRAM-style Avalon-MM burst port between a requester and the responder
interface ddram_responder_if;
   logic        ddr_rd;
   logic        ddr_wr;
   logic [28:0] ddr_addr;
   logic [7:0]  ddr_burstLength;
   logic [7:0]  ddr_mask;
   logic [63:0] ddr_din;
   logic [63:0] ddr_dout;
   logic        ddr_waitReq;
   logic        ddr_valid;

   modport master (
      output ddr_rd, ddr_wr, ddr_addr, ddr_burstLength, ddr_mask, ddr_din,
      input  ddr_dout, ddr_waitReq, ddr_valid
   );

   modport slave (
      input  ddr_rd, ddr_wr, ddr_addr, ddr_burstLength, ddr_mask, ddr_din,
      output ddr_dout, ddr_waitReq, ddr_valid
   );
endinterface

// File: rtl/ddram_responder.sv
// rtl/ddram_responder.sv - block-RAM backed stand-in for the DDRAM port with read latency and stall injection
module ddram_responder #(
   parameter int ADDR_WIDTH   = 12,
   parameter int READ_LATENCY = 4,
   parameter int STALL_PERIOD = 0
) (
   input  logic               clock,
   input  logic               reset_n,
   ddram_responder_if.slave   ddr,
   output logic               error
);
   typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ} state_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD - 1);
   localparam logic [3:0]    LAT_LAST   = 4'(READ_LATENCY - 2);

   logic [63:0] mem [0:(2**ADDR_WIDTH)-1];

   state_t        state, state_nxt;
   addr_t         base;
   logic [7:0]    count, beat;
   logic [3:0]    lat_cnt;
   logic [SW-1:0] stall_cnt;
   logic [63:0]   dout_q;
   logic          valid_q, error_q;

   logic          stall, wait_req, wr_en, wr_accept, rd_accept, rd_issue, err_set;
   addr_t         wr_addr, rd_addr;
   logic [7:0]    eff_len;
   logic          unused_addr;

   assign unused_addr = ^ddr.ddr_addr[28:ADDR_WIDTH];
   assign stall       = (STALL_PERIOD != 0) && (stall_cnt == STALL_LAST);
   assign eff_len     = (ddr.ddr_burstLength == 8'd0) ? 8'd1 : ddr.ddr_burstLength;

   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wait_req  = 1'b1;
      wr_en     = 1'b0;
      wr_accept = 1'b0;
      rd_accept = 1'b0;
      rd_issue  = 1'b0;
      err_set   = 1'b0;
      wr_addr   = addr_t'(base + addr_t'(beat));
      rd_addr   = addr_t'(base + addr_t'(beat));
      case (state)
         IDLE: begin
            wait_req = stall;
            if (!stall) begin
               // A write always wins over a simultaneous read.
               if (ddr.ddr_wr) begin
                  wr_en     = 1'b1;
                  wr_accept = 1'b1;
                  wr_addr   = ddr.ddr_addr[ADDR_WIDTH-1:0];
                  err_set   = ddr.ddr_rd || (ddr.ddr_burstLength == 8'd0);
                  if (eff_len > 8'd1) state_nxt = WRITE;
               end else if (ddr.ddr_rd) begin
                  rd_accept = 1'b1;
                  err_set   = (ddr.ddr_burstLength == 8'd0);
                  state_nxt = READ_WAIT;
               end
            end
         end
         WRITE: begin
            wait_req = 1'b0;
            err_set  = ddr.ddr_rd;
            if (ddr.ddr_wr) begin
               wr_en = 1'b1;
               if (beat == count - 8'd1) state_nxt = IDLE;
            end
         end
         READ_WAIT: begin
            // The RAM read is issued one cycle early so beat 0 lands on the latency edge.
            if (lat_cnt == LAT_LAST) begin
               rd_issue  = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            if (beat == count) state_nxt = IDLE;
            else               rd_issue  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (!reset_n) begin
         wait_req = 1'b1;
         wr_en    = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         base      <= '0;
         count     <= 8'd0;
         beat      <= 8'd0;
         lat_cnt   <= 4'd0;
         stall_cnt <= '0;
         dout_q    <= 64'd0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         if (STALL_PERIOD <= 1 || stall_cnt == STALL_LAST) stall_cnt <= '0;
         else                                                stall_cnt <= stall_cnt + SW'(1);

         if (err_set) error_q <= 1'b1;

         if (wr_accept || rd_accept) begin
            base    <= ddr.ddr_addr[ADDR_WIDTH-1:0];
            count   <= eff_len;
            beat    <= wr_accept ? 8'd1 : 8'd0;
            lat_cnt <= 4'd0;
         end else if (state == WRITE && ddr.ddr_wr) begin
            beat <= beat + 8'd1;
         end else if (state == READ_WAIT) begin
            lat_cnt <= lat_cnt + 4'd1;
         end

         valid_q <= rd_issue;
         if (rd_issue) begin
            dout_q <= mem[rd_addr];
            beat   <= beat + 8'd1;
         end
      end
   end

   // RAM contents survive reset; unmasked bytes keep their old value.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (ddr.ddr_mask[i]) mem[wr_addr][8*i +: 8] <= ddr.ddr_din[8*i +: 8];
         end
      end
   end

   assign ddr.ddr_waitReq = wait_req;
   assign ddr.ddr_valid   = valid_q;
   assign ddr.ddr_dout    = dout_q;
   assign error           = error_q;
endmodule

// File: tb/tb_ddram_responder.sv
// tb/tb_ddram_responder.sv - self-checking bench for ddram_responder against a word-array model
module tb_ddram_responder;
   localparam int AW    = 12;
   localparam int DEPTH = 4096;
   localparam int LAT   = 4;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic reset_s = 1'b0;
   logic err, err_s;

   ddram_responder_if bus ();
   ddram_responder_if bus_s ();

   ddram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .STALL_PERIOD(0)) dut (
      .clock(clock), .reset_n(reset_n), .ddr(bus.slave), .error(err));

   ddram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .STALL_PERIOD(3)) dut_s (
      .clock(clock), .reset_n(reset_s), .ddr(bus_s.slave), .error(err_s));

   always #5 clock = ~clock;

   typedef struct {
      logic [11:0] addr;
      logic [63:0] init;
      logic [63:0] wdata;
      logic [7:0]  mask;
      logic [63:0] exp;
   } vec_t;

   vec_t        vecs [5];
   logic [63:0] mem_m [DEPTH];
   logic [63:0] wdata [256];
   logic [7:0]  wmask [256];
   logic [63:0] rd_got [256];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] m);
      logic [63:0] r = old;
      for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   task automatic wr_burst(input logic [28:0] addr, input int len, input int gap_after, input int gap_len);
      int beats = (len == 0) ? 1 : len;
      int guard;
      for (int b = 0; b < beats; b++) begin
         if (gap_after >= 0 && b == gap_after + 1) begin
            repeat (gap_len) begin
               @(negedge clock);
               bus.ddr_wr = 1'b0;
            end
         end
         @(negedge clock);
         bus.ddr_wr = 1'b1;
         bus.ddr_addr = addr;
         bus.ddr_burstLength = 8'(len);
         bus.ddr_din = wdata[b];
         bus.ddr_mask = wmask[b];
         guard = 0;
         while (bus.ddr_waitReq && guard < 20) begin
            @(negedge clock);
            guard++;
         end
         if (guard >= 20) check("write accept timeout", 0, 1);
         @(posedge clock);
         mem_m[(int'(addr[11:0]) + b) % DEPTH] = merge(mem_m[(int'(addr[11:0]) + b) % DEPTH], wdata[b], wmask[b]);
      end
      @(negedge clock);
      bus.ddr_wr = 1'b0;
   endtask

   task automatic rd_burst(input logic [28:0] addr, input int len, input string name);
      int beats = (len == 0) ? 1 : len;
      logic [63:0] exp_q [$];
      int first = -1;
      int seen = 0;
      int guard = 0;
      logic gap = 1'b0;
      logic wreq_after = 1'b1;
      for (int b = 0; b < beats; b++) exp_q.push_back(mem_m[(int'(addr[11:0]) + b) % DEPTH]);
      @(negedge clock);
      bus.ddr_rd = 1'b1;
      bus.ddr_addr = addr;
      bus.ddr_burstLength = 8'(len);
      while (bus.ddr_waitReq && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 20) check({name, " accept timeout"}, 0, 1);
      @(posedge clock);
      @(negedge clock);
      bus.ddr_rd = 1'b0;
      for (int k = 1; k <= LAT + beats + 2; k++) begin
         if (k > 1) @(negedge clock);
         if (bus.ddr_valid) begin
            if (first < 0) first = k;
            if (seen < beats) begin
               check({name, " data"}, bus.ddr_dout, exp_q[seen]);
               rd_got[seen] = bus.ddr_dout;
            end
            seen++;
            if (k != first + seen - 1) gap = 1'b1;
         end
         if (k == LAT + beats) wreq_after = bus.ddr_waitReq;
      end
      check({name, " latency"}, 64'(first), 64'(LAT));
      check({name, " beats"}, 64'(seen), 64'(beats));
      check({name, " gapfree"}, 64'(gap), 0);
      check({name, " waitreq after"}, 64'(wreq_after), 0);
   endtask

   initial begin
      int vcnt;
      logic [63:0] prior;
      bus.ddr_rd = 0; bus.ddr_wr = 0; bus.ddr_addr = 0; bus.ddr_burstLength = 0;
      bus.ddr_mask = 0; bus.ddr_din = 0;
      bus_s.ddr_rd = 0; bus_s.ddr_wr = 0; bus_s.ddr_addr = 0; bus_s.ddr_burstLength = 0;
      bus_s.ddr_mask = 0; bus_s.ddr_din = 0;

      vecs[0] = '{12'h010, 64'h0, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF};
      vecs[1] = '{12'h011, 64'hFFFFFFFFFFFFFFFF, 64'h0, 8'h0F, 64'hFFFFFFFF00000000};
      vecs[2] = '{12'h012, 64'h1111111111111111, 64'hAAAAAAAAAAAAAAAA, 8'h81, 64'hAA111111111111AA};
      vecs[3] = '{12'h013, 64'hDEADBEEFCAFEF00D, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D};
      vecs[4] = '{12'h014, 64'h0, 64'h0123456789ABCDEF, 8'h3C, 64'h0000456789AB0000};

      repeat (3) @(negedge clock);
      check("reset waitreq", 64'(bus.ddr_waitReq), 1);
      check("reset valid", 64'(bus.ddr_valid), 0);
      check("reset dout", bus.ddr_dout, 0);
      check("reset error", 64'(err), 0);
      reset_n = 1'b1;
      #1;
      check("release waitreq", 64'(bus.ddr_waitReq), 0);

      // Fill the whole RAM so every later read has a known model value.
      for (int blk = 0; blk < DEPTH / 128; blk++) begin
         for (int b = 0; b < 128; b++) begin
            wdata[b] = {$urandom, $urandom};
            wmask[b] = 8'hFF;
         end
         wr_burst(29'(blk * 128), 128, -1, 0);
      end

      foreach (vecs[i]) begin
         wdata[0] = vecs[i].init;  wmask[0] = 8'hFF;
         wr_burst(29'(vecs[i].addr), 1, -1, 0);
         wdata[0] = vecs[i].wdata; wmask[0] = vecs[i].mask;
         wr_burst(29'(vecs[i].addr), 1, -1, 0);
         rd_burst(29'(vecs[i].addr), 1, "vec");
         check("vec table", rd_got[0], vecs[i].exp);
      end
      check("error after vectors", 64'(err), 0);

      prior = mem_m[12'h022];
      for (int b = 0; b < 4; b++) begin
         wdata[b] = {$urandom, $urandom};
         wmask[b] = (b == 2) ? 8'h0F : 8'hFF;
      end
      wr_burst(29'h20, 4, 1, 2);
      rd_burst(29'h20, 4, "gap burst");
      check("mask upper kept", 64'(rd_got[2][63:32]), 64'(prior[63:32]));
      check("mask lower written", 64'(rd_got[2][31:0]), 64'(wdata[2][31:0]));

      for (int b = 0; b < 3; b++) begin
         wdata[b] = {$urandom, $urandom};
         wmask[b] = 8'hFF;
      end
      wr_burst(29'h0FFF, 3, -1, 0);
      rd_burst(29'h0FFF, 3, "wrap burst");
      rd_burst(29'h0, 1, "wrap word0");
      check("wrap lands 0x000", rd_got[0], wdata[1]);
      rd_burst(29'h1, 1, "wrap word1");
      check("wrap lands 0x001", rd_got[0], wdata[2]);

      for (int i = 0; i < 40; i++) begin
         int len = $urandom_range(1, 12);
         logic [28:0] addr = {17'($urandom), 12'($urandom_range(0, DEPTH - 1))};
         if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b < len; b++) begin
               wdata[b] = {$urandom, $urandom};
               wmask[b] = 8'($urandom);
            end
            wr_burst(addr, len, $urandom_range(0, len), $urandom_range(1, 3));
         end else begin
            rd_burst(addr, len, "random read");
         end
      end
      check("error after random", 64'(err), 0);

      @(negedge clock);
      bus.ddr_rd = 1; bus.ddr_wr = 1; bus.ddr_addr = 29'h100; bus.ddr_burstLength = 1;
      bus.ddr_din = 64'hFEEDFACE12345678; bus.ddr_mask = 8'hFF;
      @(posedge clock);
      mem_m[12'h100] = 64'hFEEDFACE12345678;
      @(negedge clock);
      bus.ddr_rd = 0; bus.ddr_wr = 0;
      vcnt = 0;
      repeat (10) begin
         if (bus.ddr_valid) vcnt++;
         @(negedge clock);
      end
      check("rd+wr no read beats", 64'(vcnt), 0);
      check("rd+wr error", 64'(err), 1);
      rd_burst(29'h100, 1, "rd+wr write done");

      @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("error cleared by reset", 64'(err), 0);
      wdata[0] = 64'h0BADC0DE0BADC0DE; wmask[0] = 8'hFF;
      wr_burst(29'h300, 0, -1, 0);
      check("len0 error", 64'(err), 1);
      rd_burst(29'h300, 2, "len0 single beat");

      @(negedge clock);
      bus.ddr_rd = 1; bus.ddr_addr = 29'h40; bus.ddr_burstLength = 8;
      @(posedge clock);
      @(negedge clock);
      bus.ddr_rd = 0;
      vcnt = 0;
      for (int k = 0; k < 20 && vcnt < 2; k++) begin
         if (bus.ddr_valid) vcnt++;
         if (vcnt < 2) @(negedge clock);
      end
      check("midread reached beat 2", 64'(vcnt), 2);
      reset_n = 1'b0;
      @(negedge clock);
      check("midreset valid", 64'(bus.ddr_valid), 0);
      check("midreset waitreq", 64'(bus.ddr_waitReq), 1);
      check("midreset dout", bus.ddr_dout, 0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("midreset release waitreq", 64'(bus.ddr_waitReq), 0);
      vcnt = 0;
      repeat (12) begin
         @(negedge clock);
         if (bus.ddr_valid) vcnt++;
      end
      check("aborted beats dropped", 64'(vcnt), 0);
      rd_burst(29'h40, 8, "read after reset");

      // Stall instance: one forced waitReq cycle in three, counted from release.
      @(negedge clock);
      reset_s = 1'b1;
      #1;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge clock);
         check("stall pattern", 64'(bus_s.ddr_waitReq), 64'((k % 3) == 2));
      end
      bus_s.ddr_rd = 1; bus_s.ddr_addr = 0; bus_s.ddr_burstLength = 1;
      @(negedge clock);
      check("held rd not taken in stall", 64'(bus_s.ddr_waitReq), 0);
      @(negedge clock);
      check("held rd accepted", 64'(bus_s.ddr_waitReq), 1);
      bus_s.ddr_rd = 0;
      vcnt = 0;
      begin
         int first_s = -1;
         for (int k = 1; k <= LAT + 3; k++) begin
            if (k > 1) @(negedge clock);
            if (bus_s.ddr_valid) begin
               vcnt++;
               if (first_s < 0) first_s = k;
            end
         end
         check("stall read latency", 64'(first_s), 64'(LAT));
      end
      check("stall read beats", 64'(vcnt), 1);
      check("stall dut error", 64'(err_s), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
